// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states, latency limits.
package dmem_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 15;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/dmem_responder_if.sv
// Core-to-memory request/response bundle; the core side is the master.
interface dmem_responder_if;
    logic        req;
    logic [31:0] dAddr;
    logic [31:0] dwData;
    logic        dWrite;
    logic [1:0]  dSize;
    logic        ack;
    logic        err;
    logic [31:0] drData;
    logic        busy;

    modport master (output req, dAddr, dwData, dWrite, dSize,
                    input  ack, err, drData, busy);
    modport slave  (input  req, dAddr, dwData, dWrite, dSize,
                    output ack, err, drData, busy);
endinterface

// File: rtl/dmem_lane_align.sv
// Big-endian byte-lane steering: merges store data into a word, extracts load data, flags misalignment.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] oldWord,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic [31:0] wData,
    output logic [31:0] storeWord,
    output logic [31:0] loadVal,
    output logic        misalign
);
    logic [3:0][7:0] oldLanes, newLanes, repData;
    logic [3:0]      laneEn;

    assign oldLanes = oldWord;

    always_comb begin
        repData = wData;
        case (size)
            SZ_BYTE: repData = {4{wData[7:0]}};
            SZ_HALF: repData = {2{wData[15:0]}};
            default: ;
        endcase
    end

    // Byte offset k lives in packed lane 3-k (offset 0 is the MSB byte).
    for (genvar k = 0; k < 4; k++) begin : gLane
        localparam logic [1:0] OFS = 2'(k);
        assign laneEn[3-k]   = (size == SZ_BYTE) ? (offset == OFS) :
                               (size == SZ_HALF) ? (offset[1] == OFS[1]) : 1'b1;
        assign newLanes[3-k] = laneEn[3-k] ? repData[3-k] : oldLanes[3-k];
    end

    assign storeWord = newLanes;

    always_comb begin
        loadVal = oldWord;
        case (size)
            SZ_BYTE: loadVal = {24'b0, oldLanes[~offset]};
            SZ_HALF: loadVal = {16'b0, offset[1] ? oldWord[15:0] : oldWord[31:16]};
            default: ;
        endcase
    end

    assign misalign = ((size == SZ_HALF) && offset[0]) || (size[1] && (offset != 2'b00));
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: captures a request, waits LATENCY cycles, then performs the access
// and strobes ack (with err on misaligned / out-of-range accesses) for one cycle.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input logic             clk,
    input logic             rst,
    dmem_responder_if.slave bus
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : gBadLatency
        $error("dmem_responder: LATENCY out of range");
    end

    state_t          state, stateNext;
    logic [CNT_W-1:0] cnt;
    logic [31:0]     addrQ, wDataQ, rdQ;
    logic [1:0]      sizeQ;
    logic            writeQ, errQ;
    logic            doExec, inRange, misalign, accErr;
    logic [31:0]     oldWord, storeWord, loadVal;
    logic [AW-1:0]   wordIdx;
    logic [31:0]     mem [DEPTH_WORDS];

    assign wordIdx = addrQ[AW+1:2];
    assign inRange = {2'b00, addrQ[31:2]} < 32'(DEPTH_WORDS);
    assign oldWord = mem[wordIdx];
    assign accErr  = misalign | ~inRange;

    dmem_lane_align uAlign (
        .oldWord  (oldWord),
        .offset   (addrQ[1:0]),
        .size     (sizeQ),
        .wData    (wDataQ),
        .storeWord(storeWord),
        .loadVal  (loadVal),
        .misalign (misalign)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        doExec    = 1'b0;
        case (state)
            IDLE: if (bus.req) stateNext = WAIT;
            WAIT: if (cnt == '0) begin
                doExec    = 1'b1;
                stateNext = RESP;
            end
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            addrQ  <= '0;
            wDataQ <= '0;
            sizeQ  <= SZ_BYTE;
            writeQ <= 1'b0;
            errQ   <= 1'b0;
            rdQ    <= '0;
        end else begin
            if (state == IDLE && bus.req) begin
                addrQ  <= bus.dAddr;
                wDataQ <= bus.dwData;
                sizeQ  <= bus.dSize;
                writeQ <= bus.dWrite;
                cnt    <= CNT_W'(LATENCY - 1);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (doExec) begin
                errQ <= accErr;
                if (!writeQ) rdQ <= accErr ? 32'h0 : loadVal;
            end
        end
    end

    // No reset on the array; an asynchronous reset forces IDLE, so doExec cannot fire.
    always_ff @(posedge clk) begin
        if (doExec && writeQ && !accErr) mem[wordIdx] <= storeWord;
    end

    assign bus.ack    = (state == RESP);
    assign bus.err    = (state == RESP) & errQ;
    assign bus.drData = rdQ;
    assign bus.busy   = (state != IDLE);
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table through a scoreboard plus
// hand-written reset-abort and back-to-back sequences.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_responder_if bus ();
    dmem_responder_if bus2 ();

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut  (.clk(clk), .rst(rst), .bus(bus));
    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus2));

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        expErr;
        logic [31:0] expData;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          lat;
    } exp_t;

    int   nCmp = 0;
    int   nBad = 0;
    exp_t sbq[$];
    vec_t v[21];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic doReq(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                         input logic [31:0] wd, input logic expErr, input logic [31:0] expData,
                         input string nm);
        int   n;
        exp_t e;
        @(negedge clk);
        bus.req    = 1'b1;
        bus.dWrite = wr;
        bus.dSize  = sz;
        bus.dAddr  = addr;
        bus.dwData = wd;
        sbq.push_back('{expErr, expData, 2});
        @(posedge clk);
        #1;
        // inputs are don't-care once captured; scramble them
        bus.dAddr  = ~addr;
        bus.dwData = ~wd;
        bus.dSize  = ~sz;
        bus.dWrite = ~wr;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!bus.ack && n < 16);
        bus.req = 1'b0;
        e = sbq.pop_front();
        chk({nm, "/ack-seen"}, 32'(bus.ack), 32'd1);
        chk({nm, "/latency"}, 32'(n), 32'(e.lat));
        chk({nm, "/err"}, 32'(bus.err), 32'(e.err));
        chk({nm, "/drData"}, bus.drData, e.data);
        @(negedge clk);
        chk({nm, "/ack-1cyc"}, {31'b0, bus.ack}, 32'd0);
        chk({nm, "/err-idle"}, {31'b0, bus.err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        logic ackSeen;
        int   n;

        v[0]  = '{1'b1, SZ_WORD, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0};
        v[1]  = '{1'b0, SZ_WORD, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
        v[2]  = '{1'b1, SZ_BYTE, 32'h12,  32'hFFFFFF55, 1'b0, 32'hDEADBEEF};
        v[3]  = '{1'b0, SZ_WORD, 32'h10,  32'h0,        1'b0, 32'hDEAD55EF};
        v[4]  = '{1'b0, SZ_BYTE, 32'h11,  32'h0,        1'b0, 32'h000000AD};
        v[5]  = '{1'b0, SZ_HALF, 32'h12,  32'h0,        1'b0, 32'h000055EF};
        v[6]  = '{1'b1, SZ_WORD, 32'h14,  32'h01020304, 1'b0, 32'h000055EF};
        v[7]  = '{1'b1, SZ_HALF, 32'h13,  32'h0000AAAA, 1'b1, 32'h000055EF};
        v[8]  = '{1'b1, SZ_WORD, 32'h16,  32'hBBBBBBBB, 1'b1, 32'h000055EF};
        v[9]  = '{1'b0, SZ_WORD, 32'h14,  32'h0,        1'b0, 32'h01020304};
        v[10] = '{1'b0, SZ_HALF, 32'h11,  32'h0,        1'b1, 32'h0};
        v[11] = '{1'b0, SZ_WORD, 32'h1000, 32'h0,       1'b1, 32'h0};
        v[12] = '{1'b1, SZ_WORD, 32'h1000, 32'h11111111, 1'b1, 32'h0};
        v[13] = '{1'b1, SZ_WORD, 32'hFFC, 32'hCAFEF00D, 1'b0, 32'h0};
        v[14] = '{1'b0, SZ_WORD, 32'hFFC, 32'h0,        1'b0, 32'hCAFEF00D};
        v[15] = '{1'b0, SZ_HALF, 32'hFFE, 32'h0,        1'b0, 32'h0000F00D};
        v[16] = '{1'b0, SZ_BYTE, 32'hFFF, 32'h0,        1'b0, 32'h0000000D};
        v[17] = '{1'b1, SZ_BYTE, 32'h13,  32'h00000077, 1'b0, 32'h0000000D};
        v[18] = '{1'b1, SZ_HALF, 32'h10,  32'hFFFF1234, 1'b0, 32'h0000000D};
        v[19] = '{1'b0, 2'b11,   32'h10,  32'h0,        1'b0, 32'h12345577};
        v[20] = '{1'b0, SZ_BYTE, 32'h10,  32'h0,        1'b0, 32'h00000012};

        rst = 1'b1;
        bus.req = 1'b0;  bus.dWrite = 1'b0;  bus.dSize = SZ_WORD;  bus.dAddr = '0;  bus.dwData = '0;
        bus2.req = 1'b0; bus2.dWrite = 1'b0; bus2.dSize = SZ_WORD; bus2.dAddr = '0; bus2.dwData = '0;
        repeat (2) @(negedge clk);
        chk("reset/ack", {31'b0, bus.ack}, 32'd0);
        chk("reset/err", {31'b0, bus.err}, 32'd0);
        chk("reset/drData", bus.drData, 32'h0);
        chk("reset/busy", {31'b0, bus.busy}, 32'd0);
        chk("reset/busy2", {31'b0, bus2.busy}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 21; i++)
            doReq(v[i].wr, v[i].sz, v[i].addr, v[i].wd, v[i].expErr, v[i].expData,
                  $sformatf("vec%0d", i));

        // Abort in WAIT: the store must never land and ack must never rise.
        doReq(1'b1, SZ_WORD, 32'h20, 32'hAAAAAAAA, 1'b0, 32'h00000012, "pre-abort");
        @(negedge clk);
        bus.req = 1'b1; bus.dWrite = 1'b1; bus.dSize = SZ_WORD;
        bus.dAddr = 32'h20; bus.dwData = 32'h12345678;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("abort/ack-async", {31'b0, bus.ack}, 32'd0);
        bus.req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ackSeen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ackSeen |= bus.ack;
        end
        chk("abort/ack-never", {31'b0, ackSeen}, 32'd0);
        chk("abort/busy", {31'b0, bus.busy}, 32'd0);
        chk("abort/drData", bus.drData, 32'h0);
        doReq(1'b0, SZ_WORD, 32'h20, 32'h0, 1'b0, 32'hAAAAAAAA, "abort/no-write");

        // Reset landing in RESP drops ack asynchronously.
        @(negedge clk);
        bus.req = 1'b1; bus.dWrite = 1'b0; bus.dSize = SZ_WORD; bus.dAddr = 32'h14;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.ack && n < 16);
        chk("resp-abort/ack-up", {31'b0, bus.ack}, 32'd1);
        #1 rst = 1'b1;
        #1 chk("resp-abort/ack-drop", {31'b0, bus.ack}, 32'd0);
        chk("resp-abort/err-drop", {31'b0, bus.err}, 32'd0);
        bus.req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        doReq(1'b1, SZ_WORD, 32'h20, 32'h0, 1'b0, 32'h0, "post-abort/store0");
        doReq(1'b0, SZ_WORD, 32'h20, 32'h0, 1'b0, 32'h0, "post-abort/load0");

        // Back-to-back on the LATENCY=1 instance: req held, accepted every 3 cycles.
        @(negedge clk);
        bus2.req = 1'b1; bus2.dWrite = 1'b1; bus2.dSize = SZ_WORD;
        bus2.dAddr = 32'h40; bus2.dwData = 32'h0BADCAFE;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            chk($sformatf("b2b/ack t%0d", t), {31'b0, bus2.ack}, {31'b0, (t % 3) == 1});
            chk($sformatf("b2b/busy t%0d", t), {31'b0, bus2.busy}, {31'b0, (t % 3) != 2});
            if (bus2.ack) chk($sformatf("b2b/err t%0d", t), {31'b0, bus2.err}, 32'd0);
        end
        bus2.req = 1'b0;
        @(negedge clk);
        chk("b2b/idle", {31'b0, bus2.busy}, 32'd0);
        bus2.req = 1'b1; bus2.dWrite = 1'b0; bus2.dAddr = 32'h40;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus2.ack && n < 16);
        bus2.req = 1'b0;
        chk("b2b/load-ack", {31'b0, bus2.ack}, 32'd1);
        chk("b2b/load-lat", 32'(n), 32'd2);
        chk("b2b/load-data", bus2.drData, 32'h0BADCAFE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
